// File: rtl/cda_meas_ctrl_if.sv
// Result channel of the TDC measurement sequencer: accumulated sum, average,
// saturation flag and code extremes, delivered over a valid/ready handshake.
interface cda_meas_ctrl_if #(
    parameter int CODE_W   = 7,
    parameter int AVG_LOG2 = 3
);
    logic [CODE_W+AVG_LOG2-1:0] res_sum;
    logic [CODE_W-1:0]          res_avg;
    logic                       res_sat;
    logic                       res_valid;
    logic                       res_ready;
    logic [CODE_W-1:0]          code_min;
    logic [CODE_W-1:0]          code_max;

    modport master (
        output res_sum, res_avg, res_sat, res_valid, code_min, code_max,
        input  res_ready
    );

    modport slave (
        input  res_sum, res_avg, res_sat, res_valid, code_min, code_max,
        output res_ready
    );
endinterface

// File: rtl/cda_meas_ctrl.sv
// Measurement sequencer for the delay-line TDC: arms the converter, captures
// 2^AVG_LOG2 codes and hands back sum/average. Define CDA_CTRL_MINMAX_EN for code extremes.
module cda_meas_ctrl #(
    parameter int STAGES   = 87,
    parameter int CODE_W   = 7,
    parameter int SETTLE   = 90,
    parameter int AVG_LOG2 = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [CODE_W-1:0] tdc_code_i,
    output logic              tdc_en_o,
    output logic              busy_o,
    cda_meas_ctrl_if.master   res_if
);

    localparam int ACC_W  = CODE_W + AVG_LOG2;
    localparam int SCNT_W = AVG_LOG2 + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SETTLE  = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [CODE_W-1:0] STAGES_C    = CODE_W'(STAGES);
    localparam logic [7:0]        SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [SCNT_W-1:0] N_SAMPLES   = SCNT_W'(1 << AVG_LOG2);

    logic [1:0]        state_q, state_d;
    logic [7:0]        settle_q, settle_d;
    logic [SCNT_W-1:0] samp_q, samp_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              sat_q, sat_d;

    logic              enter_settle;
    logic              do_capture;
    logic              code_over;
    logic [CODE_W-1:0] code_clamp;

    assign enter_settle = (state_q == S_IDLE) && start_i && !abort_i;
    assign do_capture   = (state_q == S_CAPTURE) && !abort_i;
    assign code_over    = tdc_code_i > STAGES_C;
    assign code_clamp   = code_over ? STAGES_C : tdc_code_i;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        samp_d   = samp_q;
        acc_d    = acc_q;
        sat_d    = sat_q;
        case (state_q)
            S_IDLE: begin
                if (enter_settle) begin
                    state_d  = S_SETTLE;
                    settle_d = '0;
                    samp_d   = '0;
                    acc_d    = '0;
                    sat_d    = 1'b0;
                end
            end
            S_SETTLE: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d = S_CAPTURE;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            S_CAPTURE: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d  = acc_q + ACC_W'(code_clamp);
                    samp_d = samp_q + 1'b1;
                    sat_d  = sat_q | code_over;
                    if (samp_q + 1'b1 == N_SAMPLES) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_SETTLE;
                        settle_d = '0;
                    end
                end
            end
            default: begin
                if (abort_i || res_if.res_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            settle_q <= '0;
            samp_q   <= '0;
            acc_q    <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            samp_q   <= samp_d;
            acc_q    <= acc_d;
            sat_q    <= sat_d;
        end
    end

    // Every output decodes straight from registers, so no input reaches an output combinationally.
    assign tdc_en_o         = (state_q == S_SETTLE);
    assign busy_o           = (state_q != S_IDLE);
    assign res_if.res_valid = (state_q == S_DONE);
    assign res_if.res_sum   = acc_q;
    assign res_if.res_avg   = acc_q[ACC_W-1:AVG_LOG2];
    assign res_if.res_sat   = sat_q;

`ifdef CDA_CTRL_MINMAX_EN
    logic [CODE_W-1:0] min_q, min_d;
    logic [CODE_W-1:0] max_q, max_d;

    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (enter_settle) begin
            min_d = '1;
            max_d = '0;
        end else if (do_capture) begin
            if (code_clamp < min_q) min_d = code_clamp;
            if (code_clamp > max_q) max_d = code_clamp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_q <= '1;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign res_if.code_min = min_q;
    assign res_if.code_max = max_q;
`else
    assign res_if.code_min = '0;
    assign res_if.code_max = '0;
`endif

endmodule
